// File: rtl/regfile_mp.sv
// Two-write, two-read register file with write-to-read forwarding and
// per-register pending (scoreboard) tracking for issued producers.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we0,
   input  logic              we1,
   input  logic              ov0,
   input  logic              ov1,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int NREG = 2 ** ADDR_W;
   localparam int CW   = ADDR_W + 1;

   logic [DATA_W-1:0] mem_reg [NREG];
   logic [NREG-1:0]   pend_reg;
   logic [NREG-1:0]   pend_next;
   logic              eff0;
   logic              eff1;
   logic              same_addr;

   assign eff0      = we0 && !ov0 && (waddr0 != '0) && !rst;
   assign eff1      = we1 && !ov1 && (waddr1 != '0) && !rst;
   assign same_addr = (waddr0 == waddr1);

   // Port 1 takes priority when both ports target the same register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         if (eff0 && !(eff1 && same_addr)) begin
            mem_reg[waddr0] <= wdata0;
         end
         if (eff1) begin
            mem_reg[waddr1] <= wdata1;
         end
      end
   end

   // A new issue beats a completing write to the same register.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
         if (gi == 0) begin : g_zero
            assign pend_next[gi] = 1'b0;
         end else begin : g_reg
            logic set_hit;
            logic clr_hit;
            assign set_hit = issue_en && (issue_addr == ADDR_W'(gi));
            assign clr_hit = (eff0 && (waddr0 == ADDR_W'(gi))) ||
                             (eff1 && (waddr1 == ADDR_W'(gi)));
            assign pend_next[gi] = set_hit || (pend_reg[gi] && !clr_hit);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_reg <= '0;
      end else begin
         pend_reg <= pend_next;
      end
   end

   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < NREG; i++) begin
         pend_cnt = pend_cnt + CW'(pend_reg[i]);
      end
   end

   function automatic logic fwd_hit(input logic [ADDR_W-1:0] ra);
      return (BYPASS != 0) &&
             ((eff0 && (waddr0 == ra)) || (eff1 && (waddr1 == ra)));
   endfunction

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
      logic [DATA_W-1:0] val;
      val = mem_reg[ra];
      if (rst || (ra == '0)) begin
         val = '0;
      end else if ((BYPASS != 0) && eff1 && (waddr1 == ra)) begin
         val = wdata1;
      end else if ((BYPASS != 0) && eff0 && (waddr0 == ra)) begin
         val = wdata0;
      end
      return val;
   endfunction

   function automatic logic busy_port(input logic [ADDR_W-1:0] ra);
      return !rst && (ra != '0) && pend_reg[ra] && !fwd_hit(ra);
   endfunction

   always_comb begin
      rdata1 = read_port(raddr1);
      rdata2 = read_port(raddr2);
      busy1  = busy_port(raddr1);
      busy2  = busy_port(raddr2);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp: each row is applied for one
// cycle and the combinational outputs are checked before the next edge.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst;
   logic          we0, we1, ov0, ov1;
   logic [AW-1:0] waddr0, waddr1, raddr1, raddr2, issue_addr;
   logic [DW-1:0] wdata0, wdata1, rdata1, rdata2;
   logic          issue_en, busy1, busy2;
   logic [AW:0]   pend_cnt;

   int n_tests;
   int n_fail;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut (
      .clk(clk), .rst(rst),
      .we0(we0), .we1(we1), .ov0(ov0), .ov1(ov1),
      .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
      .issue_en(issue_en), .issue_addr(issue_addr),
      .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          r;
      logic          w0, o0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          w1, o1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [AW-1:0] ra1, ra2;
      logic          ie;
      logic [AW-1:0] ia;
      logic [DW-1:0] e1, e2;
      logic          eb1, eb2;
      logic [AW:0]   ec;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic w0, input logic o0, input int a0, input logic [DW-1:0] d0,
                      input logic w1, input logic o1, input int a1, input logic [DW-1:0] d1,
                      input int ra1, input int ra2, input logic ie, input int ia,
                      input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                      input logic eb1, input logic eb2, input int ec);
      vec_t v;
      v.r = r; v.w0 = w0; v.o0 = o0; v.a0 = AW'(a0); v.d0 = d0;
      v.w1 = w1; v.o1 = o1; v.a1 = AW'(a1); v.d1 = d1;
      v.ra1 = AW'(ra1); v.ra2 = AW'(ra2); v.ie = ie; v.ia = AW'(ia);
      v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.ec = (AW+1)'(ec);
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      rst = v.r;
      we0 = v.w0; ov0 = v.o0; waddr0 = v.a0; wdata0 = v.d0;
      we1 = v.w1; ov1 = v.o1; waddr1 = v.a1; wdata1 = v.d1;
      raddr1 = v.ra1; raddr2 = v.ra2; issue_en = v.ie; issue_addr = v.ia;
   endtask

   task automatic check(input string tag, input vec_t v);
      n_tests++;
      if (rdata1 !== v.e1 || rdata2 !== v.e2 || busy1 !== v.eb1 || busy2 !== v.eb2 || pend_cnt !== v.ec) begin
         n_fail++;
         $display("FAIL %s: got rdata1=%h rdata2=%h busy1=%b busy2=%b pend_cnt=%0d, expected rdata1=%h rdata2=%h busy1=%b busy2=%b pend_cnt=%0d",
                  tag, rdata1, rdata2, busy1, busy2, pend_cnt, v.e1, v.e2, v.eb1, v.eb2, v.ec);
      end else begin
         $display("[TB] %s ok: rdata1=%h rdata2=%h busy=%b%b pend_cnt=%0d", tag, rdata1, rdata2, busy1, busy2, pend_cnt);
      end
   endtask

   task automatic step(input string tag, input vec_t v);
      @(negedge clk);
      apply(v);
      #1;
      check(tag, v);
   endtask

   initial begin
      vec_t idle;
      n_tests = 0;
      n_fail  = 0;
      idle = '{r:0, w0:0, o0:0, a0:0, d0:0, w1:0, o1:0, a1:0, d1:0, ra1:0, ra2:0, ie:0, ia:0,
               e1:0, e2:0, eb1:0, eb2:0, ec:0};
      apply(idle);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      //   r  w0 o0 a0 d0          w1 o1 a1 d1          ra1 ra2 ie ia  e1          e2          b1 b2 cnt
      add(1, 1, 0, 3, 32'h77,    0, 0, 0, 0,          3,  2,  1, 2,  0,          0,          0, 0, 0);
      add(0, 1, 0, 3, 32'h1234,  0, 0, 0, 0,          3,  2,  0, 0,  32'h1234,   0,          0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          3,  0,  0, 0,  32'h1234,   0,          0, 0, 0);
      add(0, 1, 0, 7, 32'hAAAA,  1, 0, 7, 32'h5555,   7,  3,  0, 0,  32'h5555,   32'h1234,   0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          7,  7,  0, 0,  32'h5555,   32'h5555,   0, 0, 0);
      add(0, 1, 1, 4, 32'hFFFF,  0, 0, 0, 0,          4,  3,  0, 0,  0,          32'h1234,   0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          4,  7,  0, 0,  0,          32'h5555,   0, 0, 0);
      add(0, 1, 0, 8, 32'h11,    1, 0, 9, 32'h22,     8,  9,  0, 0,  32'h11,     32'h22,     0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          8,  9,  0, 0,  32'h11,     32'h22,     0, 0, 0);
      add(0, 1, 0, 0, 32'hDEAD,  1, 0, 0, 32'hBEEF,   0,  0,  1, 0,  0,          0,          0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          0,  0,  0, 0,  0,          0,          0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          5,  5,  1, 5,  0,          0,          0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          5,  5,  0, 0,  0,          0,          1, 1, 1);
      add(0, 1, 0, 5, 32'h9,     0, 0, 0, 0,          5,  3,  0, 0,  32'h9,      32'h1234,   0, 0, 1);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          5,  5,  0, 0,  32'h9,      32'h9,      0, 0, 0);
      add(0, 0, 0, 0, 0,         1, 0, 6, 32'h66,     6,  0,  1, 6,  32'h66,     0,          0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          6,  6,  1, 0,  32'h66,     32'h66,     1, 1, 1);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          6,  0,  0, 0,  32'h66,     0,          1, 0, 1);
      add(0, 1, 1, 6, 32'h99,    0, 0, 0, 0,          6,  6,  0, 0,  32'h66,     32'h66,     1, 1, 1);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          6,  5,  0, 0,  32'h66,     32'h9,      1, 0, 1);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          6,  0,  1, 6,  32'h66,     0,          1, 0, 1);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          6,  0,  0, 0,  32'h66,     0,          1, 0, 1);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          0,  0,  1, 10, 0,          0,          0, 0, 1);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          0,  0,  1, 11, 0,          0,          0, 0, 2);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          10, 11, 0, 0,  0,          0,          1, 1, 3);
      add(1, 1, 0, 3, 32'h5,     0, 0, 0, 0,          10, 3,  1, 12, 0,          0,          0, 0, 3);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          10, 6,  0, 0,  0,          0,          0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          3,  7,  0, 0,  0,          0,          0, 0, 0);
      add(0, 1, 0, 7, 32'h2,     1, 1, 7, 32'h1,      7,  12, 0, 0,  32'h2,      0,          0, 0, 0);
      add(0, 0, 0, 0, 0,         0, 0, 0, 0,          7,  12, 0, 0,  32'h2,      0,          0, 0, 0);

      foreach (vecs[i]) begin
         step($sformatf("row%0d", i), vecs[i]);
      end

      // Hand sequence: a completing write on port 1 clears one register while
      // a fresh issue to another lands in the same cycle.
      begin
         vec_t v;
         v = idle; v.ie = 1; v.ia = 13;                                  step("seq_issue13", v);
         v = idle; v.ie = 1; v.ia = 14; v.ec = 1;                        step("seq_issue14", v);
         v = idle; v.ie = 1; v.ia = 15; v.w1 = 1; v.a1 = 13; v.d1 = 32'hC0DE;
         v.ra1 = 13; v.ra2 = 14; v.e1 = 32'hC0DE; v.eb2 = 1; v.ec = 2;   step("seq_clr13_issue15", v);
         v = idle; v.ra1 = 13; v.ra2 = 15; v.e1 = 32'hC0DE; v.eb2 = 1; v.ec = 2;
         step("seq_after", v);
         v = idle; v.w0 = 1; v.a0 = 14; v.d0 = 32'h4; v.w1 = 1; v.a1 = 15; v.d1 = 32'h5;
         v.ra1 = 14; v.ra2 = 15; v.e1 = 32'h4; v.e2 = 32'h5; v.ec = 2;   step("seq_dual_clear", v);
         v = idle; v.ra1 = 14; v.ra2 = 15; v.e1 = 32'h4; v.e2 = 32'h5;  step("seq_all_clear", v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
